// File: rtl/mem_dma_master.sv
// Word-copy DMA initiator sharing the CPU data-memory bus; 3 cycles per word with grant held.
// Optional fill mode (constant pattern writes, 1 cycle per word) is enabled by defining DMA_FILL_EN.
module mem_dma_master #(
  parameter int          CNT_W                = 10,
  parameter logic [31:0] FILL_PATTERN_DEFAULT = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             mem_grant,
`ifdef DMA_FILL_EN
  input  logic             fill_mode,
  input  logic [31:0]      fill_value,
`endif
  input  logic [31:0]      Read_data,
  output logic [31:0]      Address,
  output logic [31:0]      Write_data,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_srcPtr;
  logic [31:0]      r_dstPtr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_buffer;
  logic             r_done;
  logic             w_countZero;
  logic             w_lastWord;
  logic             w_fillMode;
  logic [31:0]      w_writeData;
  logic             w_unusedBits;

  assign w_countZero  = (word_count == '0);
  assign w_lastWord   = (r_count == CNT_W'(1));
  assign w_unusedBits = ^{src_addr[1:0], dst_addr[1:0], FILL_PATTERN_DEFAULT};

`ifdef DMA_FILL_EN
  logic             r_fillMode;
  logic [31:0]      r_fillValue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fillMode  <= 1'b0;
      r_fillValue <= FILL_PATTERN_DEFAULT;
    end else if (r_state == S_IDLE && start && !w_countZero) begin
      r_fillMode  <= fill_mode;
      r_fillValue <= fill_value;
    end
  end

  assign w_fillMode  = r_fillMode;
  assign w_writeData = r_fillMode ? r_fillValue : r_buffer;
`else
  assign w_fillMode  = 1'b0;
  assign w_writeData = r_buffer;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !w_countZero) begin
          w_nextState = w_fillMode ? S_WRITE : S_READ;
`ifdef DMA_FILL_EN
          w_nextState = fill_mode ? S_WRITE : S_READ;
`endif
        end
      end
      S_READ: begin
        if (mem_grant) begin
          w_nextState = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_nextState = S_WRITE;
      end
      S_WRITE: begin
        if (mem_grant) begin
          if (w_lastWord) begin
            w_nextState = S_IDLE;
          end else begin
            w_nextState = w_fillMode ? S_WRITE : S_READ;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Bus strobes follow grant combinationally so an ungranted cycle never reaches the mux.
  always_comb begin
    Address    = 32'h0;
    Write_data = 32'h0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (r_state)
      S_READ: begin
        if (mem_grant) begin
          MemRead = 1'b1;
          Address = r_srcPtr;
        end
      end
      S_WRITE: begin
        if (mem_grant) begin
          MemWrite   = 1'b1;
          Address    = r_dstPtr;
          Write_data = w_writeData;
        end
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_srcPtr <= 32'h0;
      r_dstPtr <= 32'h0;
      r_count  <= '0;
      r_buffer <= 32'h0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_countZero) begin
              r_done <= 1'b1;
            end else begin
              r_srcPtr <= {src_addr[31:2], 2'b00};
              r_dstPtr <= {dst_addr[31:2], 2'b00};
              r_count  <= word_count;
            end
          end
        end
        S_CAPTURE: begin
          r_buffer <= Read_data;
          r_srcPtr <= r_srcPtr + 32'd4;
        end
        S_WRITE: begin
          if (mem_grant) begin
            r_dstPtr <= r_dstPtr + 32'd4;
            r_count  <= r_count - 1'b1;
            if (w_lastWord) begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed bench for mem_dma_master: memory model, transaction scoreboard and per-cycle busy/done checks.
// Fill-mode scenario is included only when DMA_FILL_EN is defined.
module tb_mem_dma_master;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [CNT_W-1:0] word_count;
  logic             mem_grant;
  logic [31:0]      Read_data;
  logic [31:0]      Address;
  logic [31:0]      Write_data;
  logic             MemRead;
  logic             MemWrite;
  logic             busy;
  logic             done;
`ifdef DMA_FILL_EN
  logic             fill_mode;
  logic [31:0]      fill_value;
`endif

  int nChecks = 0;
  int nPass   = 0;
  bit checkEn = 1'b0;

  bit [31:0] mem [bit [31:0]];
  logic [31:0] expRd[$];
  logic [31:0] expWrAddr[$];
  logic [31:0] expWrData[$];

  mem_dma_master #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .mem_grant  (mem_grant),
`ifdef DMA_FILL_EN
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
`endif
    .Read_data  (Read_data),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] memRd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Data memory with a registered read port.
  always @(posedge clk) begin
    if (MemRead) Read_data <= memRd(Address);
    if (MemWrite) mem[Address] = Write_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Scoreboard: every strobe must match the next expected bus transaction in order.
  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("strobes exclusive", {31'b0, MemRead & MemWrite}, 32'h0);
      if (MemRead || MemWrite) checkOutput("strobe only when granted", {31'b0, mem_grant}, 32'h1);
      if (MemRead) begin
        checkOutput("read expected", {31'b0, expRd.size() != 0}, 32'h1);
        if (expRd.size() != 0) checkOutput("read address", Address, expRd.pop_front());
      end
      if (MemWrite) begin
        checkOutput("write expected", {31'b0, expWrAddr.size() != 0}, 32'h1);
        if (expWrAddr.size() != 0) begin
          checkOutput("write address", Address, expWrAddr.pop_front());
          checkOutput("write data", Write_data, expWrData.pop_front());
        end
      end
      if (!MemRead && !MemWrite) begin
        checkOutput("idle Address", Address, 32'h0);
        checkOutput("idle Write_data", Write_data, 32'h0);
      end
      if (done) begin
        checkOutput("reads left at done", expRd.size(), 32'h0);
        checkOutput("writes left at done", expWrAddr.size(), 32'h0);
        checkOutput("busy at done", {31'b0, busy}, 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                               input bit fill, input logic [31:0] fv, input int doneCyc,
                               input int lo1a, input int lo1b, input int lo2a, input int lo2b,
                               input int restartCyc);
    logic [31:0] srcAl;
    logic [31:0] dstAl;
    srcAl = {src[31:2], 2'b00};
    dstAl = {dst[31:2], 2'b00};
    for (int i = 0; i < cnt; i++) begin
      if (!fill) expRd.push_back(srcAl + 32'(4 * i));
      expWrAddr.push_back(dstAl + 32'(4 * i));
      expWrData.push_back(fill ? fv : memRd(srcAl + 32'(4 * i)));
    end
    @(posedge clk);
    #1;
    start      = 1'b1;
    src_addr   = src;
    dst_addr   = dst;
    word_count = CNT_W'(cnt);
    mem_grant  = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode  = fill;
    fill_value = fv;
`endif
    for (int c = 1; c <= doneCyc + 1; c++) begin
      @(posedge clk);
      #1;
      start = (c == restartCyc);
      if (c == restartCyc) begin
        src_addr   = 32'h0000_0800;
        dst_addr   = 32'h0000_0900;
        word_count = CNT_W'(5);
      end
      mem_grant = !((c >= lo1a && c <= lo1b) || (c >= lo2a && c <= lo2b));
      @(negedge clk);
      checkOutput("busy", {31'b0, busy}, {31'b0, (cnt != 0) && (c < doneCyc)});
      checkOutput("done", {31'b0, done}, {31'b0, c == doneCyc});
    end
    start     = 1'b0;
    mem_grant = 1'b1;
    checkOutput("reads all issued", expRd.size(), 32'h0);
    checkOutput("writes all issued", expWrAddr.size(), 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    src_addr   = 32'h0;
    dst_addr   = 32'h0;
    word_count = '0;
    mem_grant  = 1'b0;
    Read_data  = 32'h0;
`ifdef DMA_FILL_EN
    fill_mode  = 1'b0;
    fill_value = 32'h0;
`endif
    mem[32'h100] = 32'd11;
    mem[32'h104] = 32'd22;
    mem[32'h108] = 32'd33;
    mem[32'h10C] = 32'd44;
    #1;
    checkOutput("reset Address", Address, 32'h0);
    checkOutput("reset Write_data", Write_data, 32'h0);
    checkOutput("reset MemRead", {31'b0, MemRead}, 32'h0);
    checkOutput("reset MemWrite", {31'b0, MemWrite}, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    checkEn = 1'b1;

    $display("[TB] four-word copy");
    applyStimulus(32'h100, 32'h200, 4, 1'b0, 32'h0, 13, 0, -1, 0, -1, 0);
    checkOutput("mem 0x200", memRd(32'h200), 32'd11);
    checkOutput("mem 0x204", memRd(32'h204), 32'd22);
    checkOutput("mem 0x208", memRd(32'h208), 32'd33);
    checkOutput("mem 0x20C", memRd(32'h20C), 32'd44);

    $display("[TB] grant stall");
    applyStimulus(32'h104, 32'h280, 1, 1'b0, 32'h0, 12, 1, 5, 8, 10, 0);
    checkOutput("mem 0x280", memRd(32'h280), 32'd22);

    $display("[TB] zero count");
    applyStimulus(32'h100, 32'h380, 0, 1'b0, 32'h0, 1, 0, -1, 0, -1, 0);
    checkOutput("mem 0x380 untouched", {31'b0, mem.exists(32'h380)}, 32'h0);

    $display("[TB] unaligned addresses, start while busy");
    applyStimulus(32'h103, 32'h402, 2, 1'b0, 32'h0, 7, 0, -1, 0, -1, 3);
    checkOutput("mem 0x400", memRd(32'h400), 32'd11);
    checkOutput("mem 0x404", memRd(32'h404), 32'd22);
    checkOutput("mem 0x900 untouched", {31'b0, mem.exists(32'h900)}, 32'h0);

    $display("[TB] reset during second write");
    expRd.push_back(32'h100);
    expRd.push_back(32'h104);
    expWrAddr.push_back(32'h500);
    expWrData.push_back(32'd11);
    @(posedge clk);
    #1;
    start      = 1'b1;
    src_addr   = 32'h100;
    dst_addr   = 32'h500;
    word_count = CNT_W'(4);
    mem_grant  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 6) reset = 1'b1;
      if (c < 6) @(negedge clk);
    end
    #1;
    checkOutput("abort MemWrite", {31'b0, MemWrite}, 32'h0);
    checkOutput("abort MemRead", {31'b0, MemRead}, 32'h0);
    checkOutput("abort Address", Address, 32'h0);
    checkOutput("abort Write_data", Write_data, 32'h0);
    checkOutput("abort busy", {31'b0, busy}, 32'h0);
    checkOutput("abort pending writes", expWrAddr.size(), 32'h0);
    expRd.delete();
    expWrAddr.delete();
    expWrData.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("no done after abort", {31'b0, done}, 32'h0);
      checkOutput("idle after abort", {31'b0, busy}, 32'h0);
    end
    checkOutput("mem 0x504 untouched", {31'b0, mem.exists(32'h504)}, 32'h0);
    applyStimulus(32'h100, 32'h600, 4, 1'b0, 32'h0, 13, 0, -1, 0, -1, 0);
    checkOutput("mem 0x600", memRd(32'h600), 32'd11);
    checkOutput("mem 0x60C", memRd(32'h60C), 32'd44);

`ifdef DMA_FILL_EN
    $display("[TB] fill mode");
    applyStimulus(32'h0, 32'h300, 3, 1'b1, 32'hDEADBEEF, 4, 0, -1, 0, -1, 0);
    checkOutput("mem 0x300", memRd(32'h300), 32'hDEADBEEF);
    checkOutput("mem 0x304", memRd(32'h304), 32'hDEADBEEF);
    checkOutput("mem 0x308", memRd(32'h308), 32'hDEADBEEF);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
